left_rotater_seq: RTL and testbench

- Multi-cycle left rotater for the ALU; the opposite-direction counterpart of the combinational right rotater.
- Rotates an operand left by a run-time amount, one bit position per clock.
- Reports result plus N/Z/V/C flags through a start/busy/done handshake.
- Shares the flag encoding of the other ALU units: bit3 N, bit2 Z, bit1 V, bit0 C.

---
 rtl/left_rotater_seq.sv | 91 +++++++++
 tb/tb_left_rotater_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/left_rotater_seq.sv
// rtl/left_rotater_seq.sv - multi-cycle left rotater, one bit per clock, with N/Z/V/C flags
module left_rotater_seq #(
   parameter int size = 16,
   parameter int m    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [size-1:0] in_a,
   input  logic [m-1:0]    shift,
   output logic            busy,
   output logic            done,
   output logic [size-1:0] out,
   output logic [3:0]      flags_n_z_v_c
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROTATE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [size-1:0] work_q, work_d;
   logic [m-1:0]    cnt_q, cnt_d;
   logic            c_last_q, c_last_d;
   logic [size-1:0] out_q, out_d;
   logic [3:0]      flags_q, flags_d;

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         work_q   <= '0;
         cnt_q    <= '0;
         c_last_q <= 1'b0;
         out_q    <= '0;
         flags_q  <= 4'b0000;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         cnt_q    <= cnt_d;
         c_last_q <= c_last_d;
         out_q    <= out_d;
         flags_q  <= flags_d;
      end
   end

   // Next-state: capture on start, rotate one bit per cycle, publish result on the last step
   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      cnt_d    = cnt_q;
      c_last_d = c_last_q;
      out_d    = out_q;
      flags_d  = flags_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               work_d   = in_a;
               cnt_d    = shift;
               c_last_d = 1'b0;
               state_d  = ROTATE;
            end
         end
         ROTATE: begin
            if (cnt_q != '0) begin
               work_d   = {work_q[size-2:0], work_q[size-1]};
               c_last_d = work_q[size-1];
               cnt_d    = cnt_q - 1'b1;
            end else begin
               out_d   = work_q;
               flags_d = {work_q[size-1], ~|work_q, 1'b0, c_last_q};
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE);
   assign out           = out_q;
   assign flags_n_z_v_c = flags_q;

endmodule

// File: tb/tb_left_rotater_seq.sv
// tb/tb_left_rotater_seq.sv - scoreboard bench for left_rotater_seq
module tb_left_rotater_seq;
   localparam int SIZE = 16;
   localparam int M    = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [SIZE-1:0] in_a = '0;
   logic [M-1:0]    shift = '0;
   logic            busy, done;
   logic [SIZE-1:0] out;
   logic [3:0]      flags;

   left_rotater_seq #(.size(SIZE), .m(M)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_a(in_a), .shift(shift),
      .busy(busy), .done(done), .out(out), .flags_n_z_v_c(flags)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [SIZE-1:0] o;
      logic [3:0]      f;
      int              due;
   } exp_t;
   exp_t sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: rotate by s mod SIZE; the last bit leaving the MSB on step s
   // is original bit (SIZE - s) mod SIZE.
   function automatic exp_t model(input logic [SIZE-1:0] a, input int s);
      exp_t e;
      int r;
      logic [SIZE-1:0] v;
      logic c;
      r = s % SIZE;
      v = (r == 0) ? a : ((a << r) | (a >> (SIZE - r)));
      c = (s == 0) ? 1'b0 : a[(SIZE - r) % SIZE];
      e.o = v;
      e.f = {v[SIZE-1], (v == '0), 1'b0, c};
      e.due = 0;
      return e;
   endfunction

   task automatic launch(input logic [SIZE-1:0] a, input int s);
      exp_t e;
      int b;
      b = 0;
      while (busy && b < 100) begin
         @(negedge clk);
         b++;
      end
      if (b >= 100) check("idle_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
      in_a  = a;
      shift = s[M-1:0];
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e = model(a, s);
      e.due = cyc + s + 1;
      sb.push_back(e);
      in_a  = $urandom;
      shift = $urandom;
   endtask

   task automatic drain();
      int b;
      b = 0;
      while (sb.size() != 0 && b < 200) begin
         @(negedge clk);
         b++;
      end
      if (b >= 200) begin
         check("drain_timeout", sb.size(), 0);
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   // Monitor: every done pulse must match the oldest expected result, on time
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && done) begin
            if (sb.size() == 0) begin
               check("spurious_done", done, 1'b0);
            end else begin
               e = sb.pop_front();
               check("out", out, e.o);
               check("flags", flags, e.f);
               check("latency", cyc, e.due);
               check("busy_in_done", busy, 1'b1);
               @(negedge clk);
               check("done_one_cycle", done, 1'b0);
               check("busy_after_done", busy, 1'b0);
            end
         end
      end
   end

   initial begin
      // Reset then idle
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("rst_out", out, 16'h0000);
         check("rst_flags", flags, 4'b0000);
         check("rst_busy", busy, 1'b0);
         check("rst_done", done, 1'b0);
      end

      // Directed cases
      launch(16'h1234, 4);  drain();
      launch(16'h8001, 1);  drain();
      launch(16'h0001, 15); drain();
      launch(16'h0000, 7);  drain();
      launch(16'hF00F, 0);  drain();

      // Start while busy is ignored
      launch(16'h00FF, 8);
      repeat (3) @(posedge clk);
      #1;
      in_a  = 16'hAAAA;
      shift = 4'd3;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      drain();
      repeat (5) begin
         @(negedge clk);
         check("no_second_op", busy, 1'b0);
      end

      // Asynchronous reset mid-rotate
      launch(16'h1234, 10);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      sb.delete();
      #1;
      check("abort_out", out, 16'h0000);
      check("abort_flags", flags, 4'b0000);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (15) @(negedge clk);
      launch(16'h8001, 1); drain();

      // Randomized operations
      for (int i = 0; i < 40; i++) begin
         launch($urandom, $urandom_range(0, (1 << M) - 1));
         if ($urandom_range(0, 1) == 1) drain();
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
